// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
// State encoding, BCD limits and a digit validity helper.
package bcd_serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_CORR = 4'd6;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  function automatic logic bcd_bad(
    input logic [3:0] d
  );
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add with decimal correction.
// Purely combinational; shared by every RUN cycle.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;
  logic [4:0] t_adj;

  // binary sum, then +6 when it leaves the decimal range
  always_comb begin
    t     = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    t_adj = t + {1'b0, BCD_CORR};
    if (t > {1'b0, BCD_MAX}) begin
      s  = t_adj[3:0];
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, LSD first, one digit per clock.
// Optional BCD_INPUT_CHECK_EN adds a sticky err flag for non-BCD digits.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] S,
  output logic                Cout
`ifdef BCD_INPUT_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  res_sr;
  logic [W-1:0]  res_nx;
  logic [W-1:0]  sum_w;
  logic [IW-1:0] idx_q;
  logic          cy_q;

  logic          load;
  logic          step;
  logic          last;

  logic [3:0]    dsum;
  logic          dco;

  bcd_digit_add u_digit (
    .a  (a_sr[3:0]),
    .b  (b_sr[3:0]),
    .ci (cy_q),
    .s  (dsum),
    .co (dco)
  );

  // new digit enters at the top; after DIGITS steps
  // digit 0 has reached bits [3:0]
  always_comb begin
    sum_w      = '0;
    sum_w[3:0] = dsum;
    res_nx     = (res_sr >> 4) | (sum_w << (W - 4));
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and datapath controls
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  // operand shifters, carry, index and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      idx_q  <= '0;
      cy_q   <= 1'b0;
      S      <= '0;
      Cout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        load: begin
          a_sr   <= A;
          b_sr   <= B;
          cy_q   <= Cin;
          idx_q  <= '0;
          res_sr <= '0;
        end
        step: begin
          a_sr   <= a_sr >> 4;
          b_sr   <= b_sr >> 4;
          cy_q   <= dco;
          idx_q  <= idx_q + IW'(1);
          res_sr <= res_nx;
          if (last) begin
            S    <= res_nx;
            Cout <= dco;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  // sticky flag for any non-BCD operand digit seen while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (load) begin
      err <= 1'b0;
    end else if (step) begin
      if (bcd_bad(a_sr[3:0]) || bcd_bad(b_sr[3:0]))
        err <= 1'b1;
    end
  end
`endif

endmodule
